// File: rtl/glm_dot_multi.sv
// glm_dot_multi
//   Multi-channel GLM dot-product stage. Streams sample lines from the input
//   FIFO and produces NUM_CH independent dot products (one per model) from a
//   single pass over the sample. Each model line is fetched for all channels
//   with one BRAM read. Results are optionally reduced by a per-operation
//   bias, then written channel-serially to the dot FIFO under backpressure.
//
//   Ports
//     clk, reset          clock, synchronous active-high reset
//     op_start            start pulse (accepted only when idle)
//     cfg_num_lines       lines per sample            (latched at op_start)
//     cfg_model_offset    first model BRAM address    (latched at op_start)
//     cfg_bias_en/bias    subtract bias from results  (latched at op_start)
//     op_busy, op_done    status / completion pulse
//     in_*                sample FIFO read port, 1-cycle read latency
//     model_*             model BRAM read port, 1-cycle latency,
//                         channel c in model_rdata[c*LW +: LW]
//     out_*               dot FIFO write port (out_ch = channel index)
module glm_dot_multi #(
   parameter int unsigned VALUES_PER_LINE = 16,
   parameter int unsigned NUM_CH          = 4,
   parameter int unsigned ADDR_W          = 16,
   parameter int unsigned FRAC_BITS       = 16
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          op_start,
   input  logic [15:0]                                   cfg_num_lines,
   input  logic [ADDR_W-1:0]                             cfg_model_offset,
   input  logic                                          cfg_bias_en,
   input  logic [31:0]                                   cfg_bias,
   output logic                                          op_busy,
   output logic                                          op_done,
   input  logic                                          in_empty,
   output logic                                          in_re,
   input  logic                                          in_rvalid,
   input  logic [32*VALUES_PER_LINE-1:0]                 in_rdata,
   output logic                                          model_re,
   output logic [ADDR_W-1:0]                             model_raddr,
   input  logic                                          model_rvalid,
   input  logic [NUM_CH*32*VALUES_PER_LINE-1:0]          model_rdata,
   input  logic                                          out_full,
   output logic                                          out_we,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
   output logic [31:0]                                   out_wdata
);
   localparam int unsigned LW   = 32 * VALUES_PER_LINE;
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CH_W:0] CH_END = (CH_W + 1)'(NUM_CH);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

   state_t              state;
   logic [15:0]         num_lines_q;
   logic [ADDR_W-1:0]   offset_q;
   logic                bias_en_q;
   logic [31:0]         bias_q;
   logic [15:0]         requested;
   logic [15:0]         processed;
   logic [CH_W:0]       ch_idx;
   logic [31:0]         acc [NUM_CH];

   logic                               prod_v;
   logic [VALUES_PER_LINE-1:0][31:0]   prod_q [NUM_CH];
   logic                               sum_v;
   logic [31:0]                        sum_q  [NUM_CH];

   logic issue;

   // Data is trusted on in_rvalid alone; model_rvalid is coincident by contract.
   logic unused_model_rvalid;
   assign unused_model_rvalid = model_rvalid;

   // Read strobes are combinational on the live in_empty so back-to-back reads
   // never overrun a FIFO holding a single entry; reset blocks a pop in the
   // cycle the operation is being abandoned.
   assign issue       = (state == S_RUN) && !reset && (requested != num_lines_q) && !in_empty;
   assign in_re       = issue;
   assign model_re    = issue;
   assign model_raddr = offset_q + ADDR_W'(requested);

   function automatic logic [31:0] lane_product(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] p;
      p = 64'(signed'(a)) * 64'(signed'(b));
      p = p >>> FRAC_BITS;
      return p[31:0];
   endfunction

   function automatic logic [31:0] line_sum(input logic [VALUES_PER_LINE-1:0][31:0] lanes);
      logic [31:0] s;
      s = '0;
      for (int unsigned l = 0; l < VALUES_PER_LINE; l++) s = s + lanes[l];
      return s;
   endfunction

   // Two-stage datapath: lane products, then per-channel line sums.
   // Returns are only accepted while an operation is in flight, so a read
   // completing after a reset never reaches the accumulators.
   always_ff @(posedge clk) begin
      if (reset) begin
         prod_v <= 1'b0;
         sum_v  <= 1'b0;
      end else begin
         prod_v <= in_rvalid && ((state == S_RUN) || (state == S_DRAIN));
         sum_v  <= prod_v;
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         for (int unsigned l = 0; l < VALUES_PER_LINE; l++) begin
            prod_q[c][l] <= lane_product(in_rdata[l*32 +: 32], model_rdata[c*LW + l*32 +: 32]);
         end
         sum_q[c] <= line_sum(prod_q[c]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         num_lines_q <= '0;
         offset_q    <= '0;
         bias_en_q   <= 1'b0;
         bias_q      <= '0;
         requested   <= '0;
         processed   <= '0;
         ch_idx      <= '0;
         op_busy     <= 1'b0;
         op_done     <= 1'b0;
         out_we      <= 1'b0;
         out_ch      <= '0;
         out_wdata   <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
      end else begin
         out_we  <= 1'b0;
         op_done <= 1'b0;
         if (issue) requested <= requested + 16'd1;
         if (sum_v) begin
            for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= acc[c] + sum_q[c];
            processed <= processed + 16'd1;
         end
         unique case (state)
            S_IDLE: begin
               if (op_start) begin
                  num_lines_q <= cfg_num_lines;
                  offset_q    <= cfg_model_offset;
                  bias_en_q   <= cfg_bias_en;
                  bias_q      <= cfg_bias;
                  requested   <= '0;
                  processed   <= '0;
                  ch_idx      <= '0;
                  op_busy     <= 1'b1;
                  for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
                  state       <= S_RUN;
               end
            end
            S_RUN: begin
               if (requested == num_lines_q) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (processed == num_lines_q) begin
                  if (bias_en_q) begin
                     for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= acc[c] - bias_q;
                  end
                  state <= S_WRITE;
               end
            end
            S_WRITE: begin
               // The extra pass with ch_idx == NUM_CH lands op_done one cycle
               // after the final registered write becomes visible.
               if (ch_idx == CH_END) begin
                  op_done <= 1'b1;
                  state   <= S_DONE;
               end else if (!out_full) begin
                  out_we    <= 1'b1;
                  out_ch    <= ch_idx[CH_W-1:0];
                  out_wdata <= acc[ch_idx[CH_W-1:0]];
                  ch_idx    <= ch_idx + 1'b1;
               end
            end
            S_DONE: begin
               op_busy <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_glm_dot_multi.sv
// tb_glm_dot_multi
//   Directed, table-driven bench for glm_dot_multi. The bench models the sample
//   FIFO (preloaded with N identical lines, optional alternating empty) and the
//   model BRAM (1-cycle latency), drives inputs just after the rising edge and
//   samples outputs on the falling edge.
module tb_glm_dot_multi;
   localparam int unsigned VPL = 16;
   localparam int unsigned NCH = 4;
   localparam int unsigned AW  = 16;
   localparam int unsigned LW  = 32 * VPL;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                op_start = 1'b0;
   logic [15:0]         cfg_num_lines = '0;
   logic [AW-1:0]       cfg_model_offset = '0;
   logic                cfg_bias_en = 1'b0;
   logic [31:0]         cfg_bias = '0;
   logic                op_busy, op_done;
   logic                in_empty = 1'b1;
   logic                in_re;
   logic                in_rvalid = 1'b0;
   logic [LW-1:0]       in_rdata = '0;
   logic                model_re;
   logic [AW-1:0]       model_raddr;
   logic                model_rvalid = 1'b0;
   logic [NCH*LW-1:0]   model_rdata = '0;
   logic                out_full = 1'b0;
   logic                out_we;
   logic [1:0]          out_ch;
   logic [31:0]         out_wdata;

   always #5 clk = ~clk;

   glm_dot_multi #(
      .VALUES_PER_LINE(VPL),
      .NUM_CH(NCH),
      .ADDR_W(AW),
      .FRAC_BITS(16)
   ) dut (
      .clk(clk), .reset(reset), .op_start(op_start),
      .cfg_num_lines(cfg_num_lines), .cfg_model_offset(cfg_model_offset),
      .cfg_bias_en(cfg_bias_en), .cfg_bias(cfg_bias),
      .op_busy(op_busy), .op_done(op_done),
      .in_empty(in_empty), .in_re(in_re), .in_rvalid(in_rvalid), .in_rdata(in_rdata),
      .model_re(model_re), .model_raddr(model_raddr), .model_rvalid(model_rvalid),
      .model_rdata(model_rdata),
      .out_full(out_full), .out_we(out_we), .out_ch(out_ch), .out_wdata(out_wdata)
   );

   typedef struct {
      string            name;
      int unsigned      n;
      logic [15:0]      off;
      logic [31:0]      samp;
      logic [3:0][31:0] mdl;
      logic             bias_en;
      logic [31:0]      bias;
      bit               toggle;
      int unsigned      full_hold;
      bit               poke;
      logic [3:0][31:0] exp;
   } vec_t;

   vec_t tbl [7];

   int unsigned total = 0;
   int unsigned bad   = 0;

   // bench-side environment state
   logic        nx_start = 1'b0, nx_reset = 1'b1, nx_full = 1'b0;
   int unsigned avail = 0;
   bit          toggle_en = 0, phase = 0;
   logic        last_re = 1'b0, last_mre = 1'b0, prev_full = 1'b0;
   int          cyc = 0, done_cyc = 0;
   int unsigned n_reads, n_addr, n_wr, n_done, empty_viol, full_viol, pair_viol;
   logic        busy_early, busy_done;
   logic [15:0] addrs   [16];
   logic [1:0]  wr_ch   [8];
   logic [31:0] wr_data [8];

   function automatic vec_t mk(input string name, input int unsigned n, input logic [15:0] off,
                               input logic [31:0] samp, input logic [3:0][31:0] mdl,
                               input logic bias_en, input logic [31:0] bias, input bit toggle,
                               input int unsigned full_hold, input bit poke,
                               input logic [3:0][31:0] exp);
      vec_t v;
      v.name = name; v.n = n; v.off = off; v.samp = samp; v.mdl = mdl;
      v.bias_en = bias_en; v.bias = bias; v.toggle = toggle;
      v.full_hold = full_hold; v.poke = poke; v.exp = exp;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: drive after the rising edge, sample on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
      reset        = nx_reset;
      op_start     = nx_start;
      out_full     = nx_full;
      in_rvalid    = last_re;
      model_rvalid = last_mre;
      in_empty     = (avail == 0) || (toggle_en && phase);
      phase        = !phase;
      @(negedge clk);
      cyc++;
      if (in_re) begin
         if (in_empty) empty_viol++;
         if (avail > 0) avail--;
         n_reads++;
      end
      if (model_re) begin
         if (n_addr < 16) addrs[n_addr] = model_raddr;
         n_addr++;
      end
      if (model_re != in_re) pair_viol++;
      last_re  = in_re;
      last_mre = model_re;
      if (out_we) begin
         if (prev_full) full_viol++;
         if (n_wr < 8) begin
            wr_ch[n_wr]   = out_ch;
            wr_data[n_wr] = out_wdata;
         end
         n_wr++;
      end
      prev_full = out_full;
      if (op_done) begin
         n_done++;
         done_cyc  = cyc;
         busy_done = op_busy;
      end
   endtask

   task automatic prep(input vec_t v);
      cfg_num_lines    = 16'(v.n);
      cfg_model_offset = v.off;
      cfg_bias_en      = v.bias_en;
      cfg_bias         = v.bias;
      for (int unsigned l = 0; l < VPL; l++) begin
         in_rdata[l*32 +: 32] = v.samp;
         for (int unsigned c = 0; c < NCH; c++) model_rdata[c*LW + l*32 +: 32] = v.mdl[c];
      end
      avail = v.n; toggle_en = v.toggle; phase = 0;
      n_reads = 0; n_addr = 0; n_wr = 0; n_done = 0;
      empty_viol = 0; full_viol = 0; pair_viol = 0;
      busy_early = 1'b0; busy_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr_ch[i]   = 'x;
         wr_data[i] = 'x;
      end
   endtask

   task automatic check_idle(input string pfx);
      check({pfx, ".in_re"},       32'(in_re),       32'd0);
      check({pfx, ".model_re"},    32'(model_re),    32'd0);
      check({pfx, ".out_we"},      32'(out_we),      32'd0);
      check({pfx, ".op_done"},     32'(op_done),     32'd0);
      check({pfx, ".op_busy"},     32'(op_busy),     32'd0);
      check({pfx, ".model_raddr"}, 32'(model_raddr), 32'd0);
      check({pfx, ".out_ch"},      32'(out_ch),      32'd0);
      check({pfx, ".out_wdata"},   out_wdata,        32'd0);
   endtask

   task automatic run_op(input vec_t v);
      int          start_cyc;
      int unsigned full_left;
      bit          seen_first;
      int unsigned addr_bad;
      prep(v);
      nx_start = 1'b1;
      step();
      start_cyc  = cyc;
      nx_start   = 1'b0;
      full_left  = 0;
      seen_first = 0;
      for (int k = 0; k < 400 && n_done == 0; k++) begin
         nx_start = v.poke && (k == 1);
         if (full_left > 0) begin
            nx_full = 1'b1;
            full_left--;
         end else begin
            nx_full = 1'b0;
         end
         step();
         if (k == 0) busy_early = op_busy;
         if (out_we && !seen_first && v.full_hold > 0) begin
            seen_first = 1;
            full_left  = v.full_hold;
         end
      end
      nx_start = 1'b0;
      nx_full  = 1'b0;
      check({v.name, ".done_seen"}, 32'(n_done != 0), 32'd1);
      for (int i = 0; i < 3; i++) step();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s.ch%0d", v.name, i),   32'(wr_ch[i]), 32'(i));
         check($sformatf("%s.data%0d", v.name, i), wr_data[i],    v.exp[i]);
      end
      check({v.name, ".writes"},     n_wr,       32'd4);
      check({v.name, ".done_count"}, n_done,     32'd1);
      check({v.name, ".reads"},      n_reads,    v.n);
      check({v.name, ".re_pairing"}, pair_viol,  32'd0);
      check({v.name, ".re_empty"},   empty_viol, 32'd0);
      check({v.name, ".we_full"},    full_viol,  32'd0);
      addr_bad = 0;
      for (int i = 0; i < int'(n_addr) && i < 16; i++) begin
         if (addrs[i] !== 16'(v.off + 16'(i))) addr_bad++;
      end
      check({v.name, ".raddr_seq"},  addr_bad,   32'd0);
      check({v.name, ".busy_early"}, 32'(busy_early), 32'd1);
      check({v.name, ".busy_done"},  32'(busy_done),  32'd1);
      check({v.name, ".busy_after"}, 32'(op_busy),    32'd0);
      if (!v.toggle && v.full_hold == 0 && v.n > 0)
         check({v.name, ".latency"}, 32'(done_cyc - start_cyc), v.n + 32'd10);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t rr;
      int   lim;
      //            name     n  off       samp          model {ch3,ch2,ch1,ch0}                             ben  bias          tog full poke expected {ch3,ch2,ch1,ch0}
      tbl[0] = mk("gain",   1, 16'h0010, 32'h00010000, {32'h00040000, 32'h00030000, 32'h00020000, 32'h00010000}, 1'b0, 32'h0,        0, 0,  0, {32'h00400000, 32'h00300000, 32'h00200000, 32'h00100000});
      tbl[1] = mk("bias",   3, 16'h0100, 32'h00008000, {4{32'h00020000}},                                       1'b1, 32'h00010000, 0, 0,  0, {4{32'h002F0000}});
      tbl[2] = mk("neg",    8, 16'hFFFC, 32'hFFFF0000, {4{32'h00010000}},                                       1'b0, 32'h0,        1, 0,  0, {4{32'hFF800000}});
      tbl[3] = mk("bkpr",   2, 16'h0020, 32'h00010000, {32'h00040000, 32'h00030000, 32'h00020000, 32'h00010000}, 1'b0, 32'h0,        0, 20, 0, {32'h00800000, 32'h00600000, 32'h00400000, 32'h00200000});
      tbl[4] = mk("zero",   0, 16'h0040, 32'h00010000, {4{32'h00010000}},                                       1'b1, 32'h00010000, 0, 0,  0, {4{32'hFFFF0000}});
      tbl[5] = mk("floor",  1, 16'h0050, 32'hFFFFFFFF, {4{32'h00008000}},                                       1'b0, 32'h0,        0, 0,  0, {4{32'hFFFFFFF0}});
      tbl[6] = mk("trunc",  1, 16'h0060, 32'h7FFF0000, {4{32'h00020000}},                                       1'b0, 32'h0,        0, 0,  0, {4{32'hFFE00000}});

      nx_reset = 1'b1;
      step();
      step();
      check_idle("reset");
      nx_reset = 1'b0;
      step();

      for (int i = 0; i < 7; i++) run_op(tbl[i]);

      // Reset after two of five lines have been read.
      rr      = tbl[0];
      rr.name = "rst";
      rr.n    = 5;
      prep(rr);
      nx_start = 1'b1;
      step();
      nx_start = 1'b0;
      lim = 0;
      while (n_reads < 2 && lim < 30) begin
         step();
         lim++;
      end
      check("rst.reads_before", n_reads, 32'd2);
      nx_reset = 1'b1;
      step();
      nx_reset = 1'b0;
      step();
      check_idle("rst.after");
      for (int i = 0; i < 4; i++) step();
      check("rst.no_writes", n_wr,   32'd0);
      check("rst.no_done",   n_done, 32'd0);

      // Fresh op after reset, with a stray op_start while running.
      rr      = tbl[0];
      rr.name = "fresh";
      rr.poke = 1;
      run_op(rr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/glm_dot_multi.md
# glm_dot_multi

Multi-channel successor of the GLM dot-product stage: streams sample lines from the input FIFO and computes `NUM_CH` independent dot products, one per model, from a single pass over the sample. Model lines for all channels are fetched with one model-BRAM read. Each result is optionally reduced by a per-operation bias, then written channel-serially to the dot FIFO under backpressure. It sits between the sample loader and the GLM gradient/update stages; one `op_start` equals one sample.

## Interface
- `VALUES_PER_LINE`, 16: 32-bit lanes per line; line width LW = 32*VALUES_PER_LINE.
- `NUM_CH`, 4: number of models/channels; power of two, 1..8.
- `ADDR_W`, 16: model BRAM address width.
- `FRAC_BITS`, 16: fixed-point fraction bits; values are signed Q(32-FRAC_BITS).FRAC_BITS.
- `clk  in  1`: clock.
- `reset  in  1`: reset, synchronous, active-high.
- `op_start  in  1`: start pulse; ignored unless IDLE.
- `cfg_num_lines  in  16`: lines per sample; sampled at op_start.
- `cfg_model_offset  in  ADDR_W`: first model address; sampled at op_start.
- `cfg_bias_en  in  1`, `cfg_bias  in  32`: subtract bias from every channel result; sampled at op_start.
- `op_busy  out  1`: high while not IDLE.
- `op_done  out  1`: one-cycle pulse, operation complete.
- `in_empty  in  1`, `in_re  out  1`, `in_rvalid  in  1`, `in_rdata  in  LW`: sample FIFO read port, 1-cycle read latency.
- `model_re  out  1`, `model_raddr  out  ADDR_W`, `model_rvalid  in  1`, `model_rdata  in  NUM_CH*LW`: model BRAM read port, 1-cycle latency; channel c occupies bits [c*LW +: LW].
- `out_full  in  1`, `out_we  out  1`, `out_ch  out  $clog2(NUM_CH)` (min 1), `out_wdata  out  32`: dot FIFO write port.

## Operation
- States: IDLE -> RUN -> DRAIN -> WRITE -> DONE -> IDLE.
- IDLE: on op_start, latch cfg_*; clear requested/processed counters and all accumulators; go to RUN.
- RUN: each cycle with requested < num_lines and !in_empty, pulse in_re and model_re together, with model_raddr = offset + requested (ADDR_W wrap); requested++. When requested == num_lines, go to DRAIN.
- Compute per channel on each in_rvalid: lane product = (a*b, 64-bit signed) >>> FRAC_BITS, truncated to 32 bits. Line sum = 32-bit wrapping sum of the lanes. The accumulator adds the line sum with 32-bit wrap. On each accumulate, processed++.
- DRAIN: wait until processed == num_lines, then apply `acc[c] -= cfg_bias` if bias_en (32-bit wrap), and go to WRITE.
- WRITE: ch walks 0..NUM_CH-1. Each cycle with !out_full, register out_we=1, out_ch=ch, out_wdata=acc[ch], then ch++. After the last channel, go to DONE.
- DONE: op_done=1 for one cycle, then IDLE.
- cfg_num_lines==0: RUN falls straight through to DRAIN with zero accumulators, so the outputs are 0 or -bias.
- in_rvalid and model_rvalid are always coincident. A mismatch is a protocol error; the block keys on in_rvalid.

## Timing
- Reset values: in_re, model_re, out_we, op_done, op_busy = 0; model_raddr, out_ch, out_wdata = 0; state IDLE; accumulators 0.
- Reset mid-operation returns to IDLE next cycle. Outstanding FIFO reads are discarded and the FIFO is not drained. The next op has no residual state.
- Issue at cycle T; data at T+1; product register T+2; line-sum register T+3; accumulator updated T+4.
- Full rate is 1 line/cycle. in_re is never asserted while in_empty was sampled high.
- out_full must assert with ≥1 free entry; the block writes at most one entry after out_full rises.
- Unstalled latency, op_start to op_done, is num_lines + NUM_CH + 6 cycles.
- op_done is asserted in the cycle after the last out_we. op_busy is high from the cycle after op_start through the op_done cycle.

## Test plan
- Gain scaling: N=1, sample all 0x00010000, model ch c all (c+1)*0x00010000 -> out_wdata 0x00100000, 0x00200000, 0x00300000, 0x00400000 on out_ch 0..3; one op_done.
- Bias: N=3, sample 0x00008000, model ch0 0x00020000, bias_en=1, bias 0x00010000 -> ch0 = 0x002F0000 (47.0).
- Negative values and sparse input: sample 0xFFFF0000, model 0x00010000, N=8, in_empty toggling every cycle -> each channel 0xFF800000 (-128.0); no in_re while empty; model_raddr offset..offset+7.
- Backpressure: out_full held high 20 cycles after the first write -> no out_we while full, ch order preserved, 4 writes total.
- Zero lines: N=0, bias_en=1, bias 0x00010000 -> 4 writes of 0xFFFF0000, op_done, no reads.
- Reset recovery: reset after 2 of 5 lines -> all outputs 0 next cycle; a fresh N=1 op matches the Gain scaling case; op_start during RUN is ignored.
